// File: rtl/fpcmult_pipe.sv
// rtl/fpcmult_pipe.sv - elastic pipelined fixed-point complex multiplier, c = a*b or a*conj(b)
module fpcmult_pipe #(
    parameter int N      = 32,
    parameter int D      = 16,
    parameter int STAGES = 3,
    parameter int ROUND  = 0,
    parameter int SAT    = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic         conj,
    input  logic [N-1:0] ar,
    input  logic [N-1:0] ac,
    input  logic [N-1:0] br,
    input  logic [N-1:0] bc,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [N-1:0] cr,
    output logic [N-1:0] cc
);

    localparam int P = 2 * N;
    localparam int W = 2 * N + 2;
    localparam int L = STAGES - 1;
    localparam logic signed [W-1:0] MAXV = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {{(W-N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic signed [W-1:0] RND  = W'(1) << (D - 1);

    logic signed [P-1:0] rr_q [1:L];
    logic signed [P-1:0] ii_q [1:L];
    logic signed [P-1:0] ri_q [1:L];
    logic signed [P-1:0] ir_q [1:L];
    logic                conj_q [1:L];
    logic [STAGES:1]     valid;
    logic [STAGES:1]     ready;
    logic                rdy_en;

    logic signed [P-1:0] rr_d, ii_d, ri_d, ir_d;
    logic signed [W-1:0] rr_x, ii_x, ri_x, ir_x, re_s, im_s;
    logic [N-1:0]        cr_d, cc_d;

    function automatic logic [N-1:0] scale(input logic signed [W-1:0] s);
        logic signed [W-1:0] q;
        q = (ROUND != 0) ? ((s + RND) >>> D) : (s >>> D);
        if (SAT != 0 && q > MAXV)
            scale = MAXV[N-1:0];
        else if (SAT != 0 && q < MINV)
            scale = MINV[N-1:0];
        else
            scale = q[N-1:0];
    endfunction

    // Ready ripples back from the consumer; a stage may load if it is empty or its successor moves.
    always_comb begin
        logic r;
        r     = send_rdy;
        ready = '0;
        for (int i = STAGES; i >= 1; i--) begin
            r        = !valid[i] || r;
            ready[i] = r;
        end
    end

    assign recv_rdy = rdy_en && ready[1];
    assign send_val = valid[STAGES];

    always_comb begin
        rr_d = P'($signed(ar)) * P'($signed(br));
        ii_d = P'($signed(ac)) * P'($signed(bc));
        ri_d = P'($signed(ar)) * P'($signed(bc));
        ir_d = P'($signed(ac)) * P'($signed(br));
    end

    always_comb begin
        rr_x = W'(rr_q[L]);
        ii_x = W'(ii_q[L]);
        ri_x = W'(ri_q[L]);
        ir_x = W'(ir_q[L]);
        re_s = conj_q[L] ? (rr_x + ii_x) : (rr_x - ii_x);
        im_s = conj_q[L] ? (ir_x - ri_x) : (ri_x + ir_x);
        cr_d = scale(re_s);
        cc_d = scale(im_s);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en <= 1'b0;
            valid  <= '0;
            cr     <= '0;
            cc     <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (ready[1])
                valid[1] <= recv_val && rdy_en;
            for (int i = 2; i <= STAGES; i++)
                if (ready[i])
                    valid[i] <= valid[i-1];
            if (ready[STAGES] && valid[L]) begin
                cr <= cr_d;
                cc <= cc_d;
            end
        end
    end

    // Operand products carry no reset; their validity is tracked by the valid chain alone.
    always_ff @(posedge clk) begin
        if (recv_val && recv_rdy) begin
            rr_q[1]   <= rr_d;
            ii_q[1]   <= ii_d;
            ri_q[1]   <= ri_d;
            ir_q[1]   <= ir_d;
            conj_q[1] <= conj;
        end
        for (int i = 2; i < STAGES; i++)
            if (ready[i] && valid[i-1]) begin
                rr_q[i]   <= rr_q[i-1];
                ii_q[i]   <= ii_q[i-1];
                ri_q[i]   <= ri_q[i-1];
                ir_q[i]   <= ir_q[i-1];
                conj_q[i] <= conj_q[i-1];
            end
    end

endmodule

// File: tb/tb_fpcmult_pipe.sv
// tb/tb_fpcmult_pipe.sv - directed bench for fpcmult_pipe (truncate/saturate and round/wrap builds)
module tb_fpcmult_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        recv_val = 1'b0;
    logic        conj = 1'b0;
    logic        send_rdy = 1'b1;
    logic [31:0] ar = '0, ac = '0, br = '0, bc = '0;
    logic        recv_rdy, send_val, recv_rdy2, send_val2;
    logic [31:0] cr, cc, cr2, cc2;

    int          checks = 0;
    int          failures = 0;
    int          emitted = 0;
    logic [63:0] exp_q[$];
    logic [63:0] pend;

    always #5 clk = ~clk;

    fpcmult_pipe #(.N(32), .D(16), .STAGES(3), .ROUND(0), .SAT(1)) u_dut (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy), .conj(conj),
        .ar(ar), .ac(ac), .br(br), .bc(bc), .send_val(send_val), .send_rdy(send_rdy),
        .cr(cr), .cc(cc)
    );

    fpcmult_pipe #(.N(32), .D(16), .STAGES(3), .ROUND(1), .SAT(0)) u_rnd (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy2), .conj(conj),
        .ar(ar), .ac(ac), .br(br), .bc(bc), .send_val(send_val2), .send_rdy(send_rdy),
        .cr(cr2), .cc(cc2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a_r, input logic [31:0] a_c, input logic [31:0] b_r,
                         input logic [31:0] b_c, input logic cj, input logic [31:0] e_r,
                         input logic [31:0] e_c);
        ar = a_r; ac = a_c; br = b_r; bc = b_c; conj = cj;
        recv_val = 1'b1;
        pend = {e_r, e_c};
    endtask

    task automatic drive_item(input int k);
        drive(32'((k + 1) << 16), 32'h00020000, 32'h00010000, 32'h0, k[0],
              32'((k + 1) << 16), 32'h00020000);
    endtask

    task automatic cycle(output logic acc);
        logic        emit;
        logic [31:0] ocr, occ;
        logic [63:0] e;
        #1;
        acc  = recv_val && recv_rdy;
        emit = send_val && send_rdy;
        ocr  = cr;
        occ  = cc;
        @(posedge clk);
        #1;
        if (emit) begin
            emitted++;
            check("emit_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("stream_cr", ocr, e[63:32]);
                check("stream_cc", occ, e[31:0]);
            end
        end
        if (acc)
            exp_q.push_back(pend);
    endtask

    task automatic single(input string tag, input logic [31:0] a_r, input logic [31:0] a_c,
                          input logic [31:0] b_r, input logic [31:0] b_c, input logic cj,
                          input logic [31:0] e_r, input logic [31:0] e_c,
                          input logic [31:0] e2_r, input logic [31:0] e2_c);
        ar = a_r; ac = a_c; br = b_r; bc = b_c; conj = cj;
        recv_val = 1'b1;
        #1;
        check({tag, "_recv_rdy"}, recv_rdy, 1'b1);
        @(posedge clk);
        #1;
        recv_val = 1'b0;
        check({tag, "_lat1"}, send_val, 1'b0);
        tick();
        check({tag, "_lat2"}, send_val, 1'b0);
        tick();
        check({tag, "_send_val"}, send_val, 1'b1);
        check({tag, "_cr"}, cr, e_r);
        check({tag, "_cc"}, cc, e_c);
        check({tag, "_rnd_send_val"}, send_val2, 1'b1);
        check({tag, "_rnd_cr"}, cr2, e2_r);
        check({tag, "_rnd_cc"}, cc2, e2_c);
        tick();
        check({tag, "_drained"}, send_val, 1'b0);
    endtask

    initial begin
        logic        acc;
        logic [31:0] snap_cr;
        int          k, n;

        #2 reset = 1'b0;
        tick();
        tick();
        check("rst_send_val", send_val, 1'b0);
        check("rst_recv_rdy", recv_rdy, 1'b0);
        check("rst_recv_rdy_rnd", recv_rdy2, 1'b0);
        check("rst_cr", cr, 32'h0);
        check("rst_cc", cc, 32'h0);
        #2 reset = 1'b1;
        check("release_recv_rdy", recv_rdy, 1'b0);
        tick();
        check("first_cycle_recv_rdy", recv_rdy, 1'b1);

        single("basic", 32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b0,
               32'hFFFB0000, 32'h000A0000, 32'hFFFB0000, 32'h000A0000);
        single("conj", 32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b1,
               32'h000B0000, 32'h00020000, 32'h000B0000, 32'h00020000);

        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                drive(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b0,
                      32'hFFFB0000, 32'h000A0000);
            else
                drive(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b1,
                      32'h000B0000, 32'h00020000);
            cycle(acc);
        end
        recv_val = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cycle(acc);
            n++;
        end
        check("alt_drain_cycles", n, 3);

        single("round", 32'h00000001, 32'h0, 32'h00008000, 32'h0, 1'b0,
               32'h0, 32'h0, 32'h00000001, 32'h0);
        single("sat_pos", 32'h7FFF0000, 32'h0, 32'h7FFF0000, 32'h0, 1'b0,
               32'h7FFFFFFF, 32'h0, 32'h00010000, 32'h0);
        single("sat_neg", 32'h7FFF0000, 32'h0, 32'h80000000, 32'h0, 1'b0,
               32'h80000000, 32'h0, 32'h80000000, 32'h0);

        emitted  = 0;
        send_rdy = 1'b0;
        k = 0;
        snap_cr = '0;
        for (int c = 0; c < 10; c++) begin
            if (k < 8)
                drive_item(k);
            cycle(acc);
            if (acc)
                k++;
            if (c == 3)
                snap_cr = cr;
        end
        check("bp_accepted", k, 3);
        check("bp_recv_rdy", recv_rdy, 1'b0);
        check("bp_send_val", send_val, 1'b1);
        check("bp_cr_stable", cr, snap_cr);
        check("bp_cr", cr, 32'h00010000);
        check("bp_cc", cc, 32'h00020000);
        send_rdy = 1'b1;
        n = 0;
        while ((k < 8 || exp_q.size() != 0) && n < 40) begin
            if (k < 8)
                drive_item(k);
            else
                recv_val = 1'b0;
            cycle(acc);
            if (acc)
                k++;
            n++;
        end
        recv_val = 1'b0;
        check("bp_emitted", emitted, 8);
        check("bp_queue_empty", exp_q.size(), 0);

        send_rdy = 1'b0;
        drive(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b0,
              32'hFFFB0000, 32'h000A0000);
        cycle(acc);
        drive(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b1,
              32'h000B0000, 32'h00020000);
        cycle(acc);
        recv_val = 1'b0;
        cycle(acc);
        check("inflight_send_val", send_val, 1'b1);
        reset = 1'b0;
        #1;
        check("async_rst_send_val", send_val, 1'b0);
        check("async_rst_recv_rdy", recv_rdy, 1'b0);
        check("async_rst_cr", cr, 32'h0);
        exp_q.delete();
        send_rdy = 1'b1;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("post_reset_quiet", send_val, 1'b0);
        end
        single("after_reset", 32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b1,
               32'h000B0000, 32'h00020000, 32'h000B0000, 32'h00020000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
